edge_detect_bank: RTL and testbench
===================================

EDGE_DETECT_BANK -- requirements
Module: edge_detect_bank

Interface
REQ-001 Parameter CHANNELS, default 8: number of independent input channels; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel; legal minimum 2.
REQ-003 Parameter DEBOUNCE, default 16: consecutive differing samples needed to accept a level change; legal minimum 1.
REQ-004 Derived IDXW = max(1, clog2(CHANNELS)); CNTW = max(1, clog2(DEBOUNCE)).
REQ-005 clock  input  1  rising-edge system clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 signal  input  CHANNELS  raw asynchronous channel inputs.
REQ-008 mode  input  2*CHANNELS  per-channel edge select; bits [2i+1:2i] encode 00 disabled, 01 rising, 10 falling, 11 both.
REQ-009 clear  input  CHANNELS  per-channel pending/overrun clear, sampled each clock.
REQ-010 evt_ready  input  1  consumer accepts the presented event.
REQ-011 level  output  CHANNELS  debounced stable level per channel.
REQ-012 rising  output  CHANNELS  one-cycle pulse on each accepted 0->1 change, independent of mode.
REQ-013 falling  output  CHANNELS  one-cycle pulse on each accepted 1->0 change, independent of mode.
REQ-014 pending  output  CHANNELS  sticky flags for mode-qualified edges.
REQ-015 overrun  output  CHANNELS  sticky flags for a qualified edge arriving while pending is already set.
REQ-016 evt_valid  output  1  high when any pending bit is set.
REQ-017 evt_channel  output  IDXW  index of the lowest-numbered set pending bit; 0 when evt_valid=0.
REQ-018 evt_rising  output  1  polarity of the most recent qualified edge on evt_channel (1 rising, 0 falling).

Function
REQ-019 Each signal bit SHALL pass through a SYNC_STAGES flop chain; the last stage is the synchronised sample s[i].
REQ-020 Debounce: if s[i]==level[i], counter[i] <= 0; else counter[i] increments, and when it equals DEBOUNCE-1, level[i] <= s[i] and counter[i] <= 0.
REQ-021 With DEBOUNCE=1, level[i] SHALL update on the first differing sample.
REQ-022 A glitch shorter than DEBOUNCE samples SHALL never change level[i] or produce a pulse.
REQ-023 rising[i] and falling[i] SHALL be registered and high for exactly the cycle in which level[i] first shows its new value.
REQ-024 Latency: an input change held stable SHALL appear on level/rising/falling after exactly SYNC_STAGES+DEBOUNCE rising clock edges.
REQ-025 Qualified edge: rising[i] with mode bit 2i set, or falling[i] with mode bit 2i+1 set; mode 00 never qualifies.
REQ-026 On a qualified edge: pending[i] <= 1 and pol[i] <= edge polarity.
REQ-027 On a qualified edge while pending[i]=1: overrun[i] <= 1 and pol[i] is overwritten with the newest polarity.
REQ-028 clear[i]=1 SHALL reset pending[i] and overrun[i] next cycle.
REQ-029 A qualified edge in the same cycle as clear[i] or an event handshake on channel i SHALL win: pending[i]=1, and overrun[i] is not set.
REQ-030 evt_valid, evt_channel and evt_rising SHALL be combinational from the pending and pol registers via a lowest-index-first priority encoder.
REQ-031 On evt_valid & evt_ready, pending[evt_channel] SHALL clear next cycle; the next-lowest pending channel is presented the following cycle.
REQ-032 evt_ready with evt_valid=0 SHALL have no effect.
REQ-033 Changing mode SHALL affect only edges occurring after the change and SHALL NOT alter existing pending bits.

Reset
REQ-034 Reset SHALL asynchronously clear all synchroniser flops, counters, level, rising, falling, pending, overrun and pol to 0.
REQ-035 After reset, an input already held high SHALL produce a normal rising pulse SYNC_STAGES+DEBOUNCE edges after reset release.
REQ-036 Reset asserted mid-debounce SHALL discard the partial count with no pulse.

Verification (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE=4)
REQ-037 mode[1:0]=01, signal[0] 0->1 held -> rising[0] high exactly one cycle, 6 edges later; pending[0]=1, evt_valid=1, evt_channel=0, evt_rising=1.
REQ-038 signal[1] high for 3 cycles then low -> level[1], rising[1] and pending[1] all remain 0.
REQ-039 ch1 and ch3 (mode 11) edges accepted in the same cycle, evt_ready=1 -> evt_channel=1, then 3 on the next cycle, then evt_valid=0.
REQ-040 ch2 mode 11: rise accepted, then fall accepted with no handshake -> overrun[2]=1, evt_rising=0; clear[2]=1 -> pending[2]=overrun[2]=0.
REQ-041 clear[0] coincides with a qualified edge on ch0 -> pending[0] stays 1, overrun[0]=0.
REQ-042 Reset pulsed 3 cycles into a debounce with the input held high -> all outputs 0, then rising pulse 6 edges after reset release.

Source files
------------

// File: rtl/edge_detect_bank.sv
// Bank of independent input channels: synchronise, debounce, detect edges and
// queue mode-qualified edges as events served lowest channel first.
module edge_detect_bank #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16,
    localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNTW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   signal,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clear,
    input  logic                  evt_ready,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   rising,
    output logic [CHANNELS-1:0]   falling,
    output logic [CHANNELS-1:0]   pending,
    output logic [CHANNELS-1:0]   overrun,
    output logic                  evt_valid,
    output logic [IDXW-1:0]       evt_channel,
    output logic                  evt_rising
);

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE - 1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;
    logic [CNTW-1:0]     cnt_q  [CHANNELS];
    logic [CHANNELS-1:0] pol_q;
    logic [CHANNELS-1:0] mode_rise;
    logic [CHANNELS-1:0] mode_fall;
    logic [CHANNELS-1:0] qual;
    logic [CHANNELS-1:0] ack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= signal;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The counter tracks how long s has disagreed with level; any agreeing
    // sample restarts it, so short glitches never reach the accept point.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
            level   <= '0;
            rising  <= '0;
            falling <= '0;
        end else begin
            rising  <= '0;
            falling <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (s[i] == level[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i]   <= '0;
                    level[i]   <= s[i];
                    rising[i]  <= s[i];
                    falling[i] <= ~s[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mode_rise = '0;
        mode_fall = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mode_rise[i] = mode[2*i];
            mode_fall[i] = mode[2*i+1];
        end
    end

    assign qual = (rising & mode_rise) | (falling & mode_fall);

    // Lowest-index pending channel is presented; scanning downward lets the
    // last assignment (the lowest index) win.
    always_comb begin
        evt_valid   = |pending;
        evt_channel = '0;
        evt_rising  = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                evt_channel = IDXW'(i);
                evt_rising  = pol_q[i];
            end
        end
    end

    // Handshake: an event transfers on a clock edge where evt_valid and
    // evt_ready are both high; evt_ready while evt_valid is low is ignored.
    always_comb begin
        ack = '0;
        for (int i = 0; i < CHANNELS; i++)
            ack[i] = evt_valid & evt_ready & (evt_channel == IDXW'(i));
    end

    // A new qualified edge beats a same-cycle clear or acknowledge, and in
    // that case is not counted as an overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
            overrun <= '0;
            pol_q   <= '0;
        end else begin
            pending <= (pending & ~(clear | ack)) | qual;
            overrun <= (overrun & ~clear) | (qual & pending & ~clear & ~ack);
            pol_q   <= (pol_q & ~qual) | (qual & rising);
        end
    end

endmodule

// File: tb/tb_edge_detect_bank.sv
// Directed bench for edge_detect_bank (4 channels, 2 sync stages, debounce 4)
// with a scoreboard for edge pulses and event handshakes.
module tb_edge_detect_bank;

    localparam int CH  = 4;
    localparam int SYN = 2;
    localparam int DEB = 4;
    localparam int LAT = SYN + DEB;

    logic          clock = 1'b0;
    logic          reset;
    logic [CH-1:0] signal;
    logic [2*CH-1:0] mode;
    logic [CH-1:0] clear;
    logic          evt_ready;
    logic [CH-1:0] level, rising, falling, pending, overrun;
    logic          evt_valid;
    logic [1:0]    evt_channel;
    logic          evt_rising;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // {cycle, rising, falling} expected for each edge pulse
    logic [39:0] exp_q[$];
    // {channel, polarity} expected for each handshake
    logic [2:0]  hs_q[$];

    edge_detect_bank #(.CHANNELS(CH), .SYNC_STAGES(SYN), .DEBOUNCE(DEB)) dut (
        .clock(clock), .reset(reset), .signal(signal), .mode(mode), .clear(clear),
        .evt_ready(evt_ready), .level(level), .rising(rising), .falling(falling),
        .pending(pending), .overrun(overrun), .evt_valid(evt_valid),
        .evt_channel(evt_channel), .evt_rising(evt_rising)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_pulse(input int at, input logic [CH-1:0] r, input logic [CH-1:0] f);
        exp_q.push_back({32'(at), r, f});
    endtask

    // Monitor: samples just after the falling edge, when all inputs are settled.
    always begin
        logic [39:0] e;
        logic [2:0]  h;
        @(negedge clock);
        #1;
        if ((rising | falling) != '0) begin
            if (exp_q.size() == 0) begin
                check("pulse_unexpected", {32'(cyc), rising, falling}, 40'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse", {32'(cyc), rising, falling}, e);
            end
        end
        if (evt_valid && evt_ready) begin
            if (hs_q.size() == 0) begin
                check("handshake_unexpected", {evt_channel, evt_rising}, 3'd0);
            end else begin
                h = hs_q.pop_front();
                check("handshake", {evt_channel, evt_rising}, h);
            end
        end
    end

    initial begin
        int c;
        reset = 1'b1; signal = '0; mode = '0; clear = '0; evt_ready = 1'b0;
        step(3);
        check("rst_level", level, 0);
        check("rst_pulses", {rising, falling}, 0);
        check("rst_pending", {pending, overrun}, 0);
        check("rst_evt", {evt_valid, evt_channel, evt_rising}, 0);
        reset = 1'b0;
        mode = 8'b11_11_11_01;
        step(2);

        // ch0 rising, mode 01
        signal[0] = 1'b1; c = cyc; expect_pulse(c + LAT, 4'b0001, 4'b0000);
        step(LAT + 1);
        check("t1_pending", pending, 4'b0001);
        check("t1_evt", {evt_valid, evt_channel, evt_rising}, {1'b1, 2'd0, 1'b1});
        check("t1_level", level, 4'b0001);
        hs_q.push_back({2'd0, 1'b1});
        evt_ready = 1'b1; step(1); evt_ready = 1'b0;
        check("t1_acked", {evt_valid, pending}, 0);

        // ch1 glitch of 3 samples
        signal[1] = 1'b1; step(3); signal[1] = 1'b0; step(10);
        check("t2_level", level, 4'b0001);
        check("t2_pending", pending, 0);

        // ch1 and ch3 accepted together, served lowest first
        signal[1] = 1'b1; signal[3] = 1'b1; c = cyc; expect_pulse(c + LAT, 4'b1010, 4'b0000);
        step(LAT + 1);
        check("t3_pending", pending, 4'b1010);
        check("t3_first", evt_channel, 2'd1);
        hs_q.push_back({2'd1, 1'b1}); hs_q.push_back({2'd3, 1'b1});
        evt_ready = 1'b1; step(1);
        check("t3_second", {evt_valid, evt_channel}, {1'b1, 2'd3});
        step(1);
        check("t3_empty", evt_valid, 1'b0);
        evt_ready = 1'b0;

        // ch2 rise then fall without handshake: overrun, newest polarity
        signal[2] = 1'b1; c = cyc; expect_pulse(c + LAT, 4'b0100, 4'b0000);
        step(LAT + 2);
        check("t4_rise", {pending, overrun, evt_rising}, {4'b0100, 4'b0000, 1'b1});
        signal[2] = 1'b0; c = cyc; expect_pulse(c + LAT, 4'b0000, 4'b0100);
        step(LAT + 2);
        check("t4_overrun", {pending, overrun}, {4'b0100, 4'b0100});
        check("t4_evt", {evt_valid, evt_channel, evt_rising}, {1'b1, 2'd2, 1'b0});
        clear = 4'b0100; step(1); clear = '0;
        check("t4_clear", {pending, overrun, evt_valid}, 0);

        // ch0: clear coincides with a new qualified edge while pending
        mode = 8'hFF;
        signal[0] = 1'b0; c = cyc; expect_pulse(c + LAT, 4'b0000, 4'b0001);
        step(LAT + 2);
        check("t5_pend", {pending, evt_rising}, {4'b0001, 1'b0});
        signal[0] = 1'b1; c = cyc; expect_pulse(c + LAT, 4'b0001, 4'b0000);
        step(LAT);
        clear = 4'b0001; step(1); clear = '0;
        check("t5_win", {pending, overrun, evt_rising}, {4'b0001, 4'b0000, 1'b1});
        hs_q.push_back({2'd0, 1'b1});
        evt_ready = 1'b1; step(1); evt_ready = 1'b0;
        check("t5_acked", pending, 0);

        // mode change to disabled on ch3: pulse still appears, no pending
        mode = 8'h3F;
        signal[3] = 1'b0; c = cyc; expect_pulse(c + LAT, 4'b0000, 4'b1000);
        step(LAT + 2);
        check("t6_no_pend", {pending, level}, {4'b0000, 4'b0011});

        // reset mid-debounce on ch2; held-high inputs rise again after release
        signal[2] = 1'b1; step(SYN + 2);
        reset = 1'b1; #1;
        check("t7_rst_outs", {level, rising, falling, pending, overrun}, 0);
        check("t7_rst_evt", {evt_valid, evt_channel, evt_rising}, 0);
        step(2);
        reset = 1'b0; c = cyc; expect_pulse(c + LAT, 4'b0111, 4'b0000);
        step(LAT + 1);
        check("t7_pending", {pending, level}, {4'b0111, 4'b0111});
        check("t7_evt", evt_channel, 2'd0);
        clear = 4'hF; step(1); clear = '0;
        check("t7_clear", pending, 0);

        step(3);
        check("pulse_queue_drained", exp_q.size(), 0);
        check("hs_queue_drained", hs_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
